aes_kat_bist: RTL and testbench

AES_KAT_BIST -- requirements
Module: aes_kat_bist

---
 rtl/aes_kat_bist.sv | 114 +++++++++++
 tb/tb_aes_kat_bist.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_bist.sv
// aes_kat_bist: FIPS-197 known-answer self-test sequencer for an external AES core
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_start, i_abort               one-cycle run request, run termination
//   o_key, o_key_en, i_key_ok      key, one-cycle key load strobe, key expansion complete
//   o_flag, o_din, o_din_en        1=encrypt/0=decrypt, data block, one-cycle data strobe
//   i_dout, i_dout_en              core result and its one-cycle valid strobe
//   o_busy, o_done                 run in progress, one-cycle run-complete pulse
//   o_pass, o_err_cnt, o_timeout   held outcome of the last run
module aes_kat_bist #(
   parameter int KEY_W    = 256,
   parameter int N_ITER   = 8,
   parameter int TIMEOUT  = 1023,
   parameter bit ENC_ONLY = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   output logic [KEY_W-1:0] o_key,
   output logic             o_key_en,
   input  logic             i_key_ok,
   output logic             o_flag,
   output logic [127:0]     o_din,
   output logic             o_din_en,
   input  logic [127:0]     i_dout,
   input  logic             i_dout_en,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [15:0]      o_err_cnt,
   output logic             o_timeout
);
   localparam logic [255:0] KEY_ALL = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [KEY_W-1:0] KEY = KEY_ALL[255 -: KEY_W];
   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT = KEY_W == 128 ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                                 KEY_W == 192 ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                128'h8ea2b7ca516745bfeafc49904b496089;
   typedef enum logic [2:0] {IDLE, LOAD_KEY, WAIT_KEY, ENC, WAIT_ENC, DEC, WAIT_DEC, FINISH} state_t;
   state_t state, nstate;
   logic [15:0] iter, wcnt;
   logic ev, hit, tmo, iter_end;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= nstate;
   // abort outranks both a response and a timeout landing in the same cycle
   always_comb begin
      nstate = state;
      hit = 1'b0;
      tmo = 1'b0;
      iter_end = 1'b0;
      ev = state == WAIT_KEY ? i_key_ok : i_dout_en;
      if (state != IDLE && i_abort) nstate = FINISH;
      else case (state)
         IDLE:     nstate = i_start ? LOAD_KEY : IDLE;
         LOAD_KEY: nstate = WAIT_KEY;
         ENC:      nstate = WAIT_ENC;
         DEC:      nstate = WAIT_DEC;
         FINISH:   nstate = IDLE;
         default:
            if (ev) begin
               hit = state == WAIT_ENC ? i_dout != CT : state == WAIT_DEC && i_dout != PT;
               iter_end = state == WAIT_DEC || (state == WAIT_ENC && ENC_ONLY);
               nstate = state == WAIT_KEY ? ENC : !iter_end ? DEC :
                        iter == 16'(N_ITER - 1) ? FINISH : WAIT_KEY;
            end else if (wcnt == 16'(TIMEOUT - 1)) begin
               hit = 1'b1;
               tmo = 1'b1;
               nstate = FINISH;
            end
      endcase
   end
   always_comb begin
      o_key_en = state == LOAD_KEY;
      o_din_en = state == ENC || state == DEC;
      o_done = state == FINISH;
      o_busy = state != IDLE && state != FINISH;
   end
   // wait counter restarts on every state change, so each wait state gets TIMEOUT cycles
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_key <= '0;
         o_din <= '0;
         o_flag <= 1'b0;
         o_err_cnt <= '0;
         o_pass <= 1'b0;
         o_timeout <= 1'b0;
         iter <= '0;
         wcnt <= '0;
      end else begin
         wcnt <= nstate == state ? wcnt + 16'd1 : 16'd0;
         if (state == IDLE && i_start) begin
            o_key <= KEY;
            o_err_cnt <= '0;
            o_timeout <= 1'b0;
            o_pass <= 1'b0;
            iter <= '0;
         end else begin
            if (hit && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 16'd1;
            if (tmo) o_timeout <= 1'b1;
            if (iter_end) iter <= iter + 16'd1;
            if (nstate == FINISH && state != FINISH)
               o_pass <= !i_abort && !tmo && !hit && o_err_cnt == '0;
         end
         if (nstate == ENC) begin
            o_flag <= 1'b1;
            o_din <= PT;
         end
         if (nstate == DEC) begin
            o_flag <= 1'b0;
            o_din <= CT;
         end
      end
endmodule

// File: tb/tb_aes_kat_bist.sv
// tb_aes_kat_bist: scoreboard bench for aes_kat_bist with a reactive AES core model
module tb_aes_kat_bist;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   typedef struct {bit pass; int err; bit tmo; int nk; int ne; int nd; int lat;} exp_t;
   logic clk, rst_n, start, st2, abort, key_ok, key_en, flag, din_en, dout_en, busy, done, pass, tmo_o;
   logic [255:0] key;
   logic [127:0] din, dout;
   logic [15:0] err_cnt;
   int errors = 0, checks = 0, n_done = 0, cyc = 0;
   int flip_enc, flip_dec, drop_enc, abort_dec;
   exp_t sb[$];
   aes_kat_bist #(.KEY_W(256), .N_ITER(8), .TIMEOUT(15), .ENC_ONLY(1'b0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .o_key(key), .o_key_en(key_en), .i_key_ok(key_ok),
      .o_flag(flag), .o_din(din), .o_din_en(din_en),
      .i_dout(dout), .i_dout_en(dout_en),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt), .o_timeout(tmo_o));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // encrypt-only instances for the 128- and 192-bit vectors, each with a one-cycle core
   for (genvar g = 0; g < 2; g++) begin : g_eo
      localparam int KW = (g == 1) ? 192 : 128;
      localparam logic [127:0] CTG = (g == 1) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      logic [KW-1:0] k;
      logic k_en, fl, d_en, r_en, bsy, dn, ps, to;
      logic [127:0] d, r;
      logic [15:0] ec;
      bit fin;
      aes_kat_bist #(.KEY_W(KW), .N_ITER(8), .TIMEOUT(15), .ENC_ONLY(1'b1)) u_eo (
         .i_clk(clk), .i_rst_n(rst_n), .i_start(st2), .i_abort(1'b0),
         .o_key(k), .o_key_en(k_en), .i_key_ok(1'b1),
         .o_flag(fl), .o_din(d), .o_din_en(d_en),
         .i_dout(r), .i_dout_en(r_en),
         .o_busy(bsy), .o_done(dn), .o_pass(ps), .o_err_cnt(ec), .o_timeout(to));
      initial begin
         int ne;
         bit pend;
         ne = 0;
         pend = 1'b0;
         fin = 1'b0;
         r = '0;
         r_en = 1'b0;
         forever begin
            @(negedge clk);
            r_en = pend;
            r = CTG;
            pend = d_en;
            if (k_en) chk($sformatf("eo%0d_key", KW), k, KEY256[255 -: KW]);
            if (d_en) begin
               ne++;
               chk($sformatf("eo%0d_flag", KW), fl, 1);
               chk($sformatf("eo%0d_din", KW), d, PT);
            end
            if (dn) begin
               chk($sformatf("eo%0d_pass", KW), ps, 1);
               chk($sformatf("eo%0d_err", KW), ec, 0);
               chk($sformatf("eo%0d_timeout", KW), to, 0);
               chk($sformatf("eo%0d_enc_strobes", KW), ne, 8);
               ne = 0;
               fin = 1'b1;
            end
         end
      end
   end
   // core model: answers each data strobe two cycles later, with knobs for faults
   initial begin
      int cd, ei, di;
      bit pend, ab;
      logic [127:0] res;
      dout = '0;
      dout_en = 1'b0;
      abort = 1'b0;
      pend = 1'b0;
      ab = 1'b0;
      cd = 0;
      ei = 0;
      di = 0;
      forever begin
         @(negedge clk);
         dout_en = 1'b0;
         abort = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
            ei = 0;
            di = 0;
            continue;
         end
         if (key_en) begin
            ei = 0;
            di = 0;
         end
         if (pend) begin
            cd--;
            if (cd == 0) begin
               pend = 1'b0;
               dout = res;
               dout_en = 1'b1;
               abort = ab;
            end
         end
         if (din_en) begin
            cd = 2;
            if (flag) begin
               res = ei == flip_enc ? CT256 ^ 128'd1 : CT256;
               pend = ei != drop_enc;
               ab = 1'b0;
               ei++;
            end else begin
               res = di == flip_dec ? PT ^ 128'd1 : PT;
               pend = 1'b1;
               ab = di == abort_dec;
               di++;
            end
         end
      end
   end
   // monitor: tallies strobes per run and scores each o_done against the queue
   initial begin
      int nk, ne, nd, ck;
      exp_t e;
      nk = 0;
      ne = 0;
      nd = 0;
      ck = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            nk = 0;
            ne = 0;
            nd = 0;
            continue;
         end
         if (key_en) begin
            nk++;
            ck = cyc;
            chk("key_value", key, KEY256);
         end
         if (din_en) begin
            chk("strobe_exclusive", key_en, 0);
            if (flag) begin
               ne++;
               chk("din_pt", din, PT);
            end else begin
               nd++;
               chk("din_ct", din, CT256);
            end
         end
         if (done) begin
            n_done++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got o_done=1 expected none");
            end else begin
               e = sb.pop_front();
               chk("pass", pass, e.pass);
               chk("err_cnt", err_cnt, e.err);
               chk("timeout", tmo_o, e.tmo);
               chk("busy_at_done", busy, 0);
               chk("key_strobes", nk, e.nk);
               chk("enc_strobes", ne, e.ne);
               chk("dec_strobes", nd, e.nd);
               if (e.lat >= 0) chk("done_latency", cyc - ck, e.lat);
            end
            nk = 0;
            ne = 0;
            nd = 0;
         end
      end
   end
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic reset_chk();
      chk("rst_key", key, 0);
      chk("rst_din", din, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_key_en", key_en, 0);
      chk("rst_din_en", din_en, 0);
      chk("rst_flag", flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", tmo_o, 0);
   endtask
   task automatic run(input exp_t e, input bit dbl);
      int n0;
      sb.push_back(e);
      n0 = n_done;
      pulse_start();
      if (dbl) begin
         repeat (10) @(negedge clk);
         chk("busy_mid_run", busy, 1);
         pulse_start();
      end
      for (int i = 0; i < 1000 && n_done == n0; i++) @(negedge clk);
      if (n_done == n0) begin
         checks++;
         errors++;
         $display("FAIL done_wait: got no o_done expected one within 1000 cycles");
      end
      repeat (2) @(negedge clk);
      chk("pass_held", pass, e.pass);
      flip_enc = -1;
      flip_dec = -1;
      drop_enc = -1;
      abort_dec = -1;
      key_ok = 1'b1;
   endtask
   initial begin
      int n0;
      rst_n = 1'b0;
      start = 1'b0;
      st2 = 1'b0;
      key_ok = 1'b1;
      flip_enc = -1;
      flip_dec = -1;
      drop_enc = -1;
      abort_dec = -1;
      repeat (3) @(negedge clk);
      reset_chk();
      rst_n = 1'b1;
      @(negedge clk);
      st2 = 1'b1;
      @(negedge clk);
      st2 = 1'b0;
      for (int i = 0; i < 300 && !(g_eo[0].fin && g_eo[1].fin); i++) @(negedge clk);
      chk("eo_finished", {g_eo[0].fin, g_eo[1].fin}, 2'b11);
      run('{1, 0, 0, 1, 8, 8, -1}, 1'b0);
      flip_enc = 2;
      run('{0, 1, 0, 1, 8, 8, -1}, 1'b0);
      key_ok = 1'b0;
      run('{0, 1, 1, 1, 0, 0, 16}, 1'b0);
      drop_enc = 1;
      run('{0, 1, 1, 1, 2, 1, -1}, 1'b0);
      abort_dec = 0;
      flip_dec = 0;
      run('{0, 0, 0, 1, 1, 1, -1}, 1'b0);
      run('{1, 0, 0, 1, 8, 8, -1}, 1'b1);
      pulse_start();
      repeat (20) @(negedge clk);
      chk("busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      reset_chk();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n0 = n_done;
      repeat (40) @(negedge clk);
      chk("no_done_after_rst", n_done, n0);
      chk("idle_after_rst", busy, 0);
      run('{1, 0, 0, 1, 8, 8, -1}, 1'b0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
